// File: rtl/bus_select_encoder_if.sv
// Request/select bundle between the control sequencer (master) and the
// bus select encoder (slave).
interface bus_select_encoder_if #(
    parameter int CNT_W = 8
);
    logic [31:0]      out_req;
    logic             hold;
    logic             err_clr;
    logic [4:0]       bus_sel;
    logic             sel_valid;
    logic             conflict;
    logic             conflict_sticky;
    logic             illegal_sticky;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output out_req, hold, err_clr,
        input  bus_sel, sel_valid, conflict, conflict_sticky, illegal_sticky, conflict_cnt
    );

    modport slave (
        input  out_req, hold, err_clr,
        output bus_sel, sel_valid, conflict, conflict_sticky, illegal_sticky, conflict_cnt
    );
endinterface

// File: rtl/bus_select_encoder.sv
// Priority-encodes one-hot bus drive requests into a registered 5-bit mux
// select, parking on IDLE_SEL, and tracks conflicting and reserved requests.
module bus_select_encoder #(
    parameter logic [4:0] IDLE_SEL = 5'd31,
    parameter int         NUM_SRC  = 24,
    parameter int         CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    bus_select_encoder_if.slave  bus
);

    localparam logic [31:0] LEGAL_MASK =
        (NUM_SRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_SRC) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      legal;
    logic [4:0]       grant_idx;
    logic             grant_hit;
    logic             multi_req;
    logic             reserved_req;
    logic [CNT_W-1:0] cnt_base;

    logic [4:0]       bus_sel_q,         bus_sel_d;
    logic             sel_valid_q,       sel_valid_d;
    logic             conflict_q,        conflict_d;
    logic             conflict_sticky_q, conflict_sticky_d;
    logic             illegal_sticky_q,  illegal_sticky_d;
    logic [CNT_W-1:0] conflict_cnt_q,    conflict_cnt_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        legal     = bus.out_req & LEGAL_MASK;
        grant_idx = IDLE_SEL;
        grant_hit = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 31; i >= 0; i--) begin
            if (legal[i]) begin
                grant_idx = 5'(i);
                grant_hit = 1'b1;
            end
        end

        // Two or more bits set <=> clearing the lowest set bit leaves something.
        multi_req    = (bus.out_req & (bus.out_req - 32'd1)) != 32'd0;
        reserved_req = (bus.out_req & ~LEGAL_MASK) != 32'd0;

        bus_sel_d   = bus.hold ? bus_sel_q   : grant_idx;
        sel_valid_d = bus.hold ? sel_valid_q : grant_hit;
        conflict_d  = multi_req;

        // err_clr clears first; an event in the same cycle then re-arms.
        conflict_sticky_d = (conflict_sticky_q & ~bus.err_clr) | multi_req;
        illegal_sticky_d  = (illegal_sticky_q  & ~bus.err_clr) | reserved_req;
        cnt_base          = bus.err_clr ? '0 : conflict_cnt_q;
        conflict_cnt_d    = (multi_req && cnt_base != CNT_MAX) ? cnt_base + 1'b1 : cnt_base;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (clr) begin
            bus_sel_q         <= IDLE_SEL;
            sel_valid_q       <= 1'b0;
            conflict_q        <= 1'b0;
            conflict_sticky_q <= 1'b0;
            illegal_sticky_q  <= 1'b0;
            conflict_cnt_q    <= '0;
        end else begin
            bus_sel_q         <= bus_sel_d;
            sel_valid_q       <= sel_valid_d;
            conflict_q        <= conflict_d;
            conflict_sticky_q <= conflict_sticky_d;
            illegal_sticky_q  <= illegal_sticky_d;
            conflict_cnt_q    <= conflict_cnt_d;
        end
    end

    assign bus.bus_sel         = bus_sel_q;
    assign bus.sel_valid       = sel_valid_q;
    assign bus.conflict        = conflict_q;
    assign bus.conflict_sticky = conflict_sticky_q;
    assign bus.illegal_sticky  = illegal_sticky_q;
    assign bus.conflict_cnt    = conflict_cnt_q;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Directed scoreboard bench for bus_select_encoder: expectations are pushed
// when a step is driven and popped after the following clock edge.
module tb_bus_select_encoder;

    typedef struct {
        string      name;
        logic [4:0] sel;
        logic       valid;
        logic       conf;
        logic       cstk;
        logic       istk;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic clr;
    bus_select_encoder_if #(.CNT_W(8)) bus ();

    bus_select_encoder #(
        .IDLE_SEL (5'd31),
        .NUM_SRC  (24),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [4:0] m_sel   = 5'd31;
    logic       m_valid = 1'b0;
    logic       m_conf  = 1'b0;
    logic       m_cstk  = 1'b0;
    logic       m_istk  = 1'b0;
    logic [7:0] m_cnt   = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] req, input logic h, input logic ec, input logic c);
        logic found;
        if (c) begin
            m_sel = 5'd31; m_valid = 1'b0; m_conf = 1'b0;
            m_cstk = 1'b0; m_istk = 1'b0; m_cnt = 8'd0;
        end else begin
            if (!h) begin
                found = 1'b0;
                m_sel = 5'd31;
                for (int i = 0; i < 24; i++) begin
                    if (!found && req[i]) begin
                        m_sel = 5'(i);
                        found = 1'b1;
                    end
                end
                m_valid = found;
            end
            m_conf = ($countones(req) >= 2);
            if (ec) begin
                m_cstk = 1'b0; m_istk = 1'b0; m_cnt = 8'd0;
            end
            if (m_conf) m_cstk = 1'b1;
            if (req[31:24] != 8'd0) m_istk = 1'b1;
            if (m_conf && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end
    endtask

    task automatic step(input string name, input logic [31:0] req, input logic h,
                        input logic ec, input logic c, input bit do_check = 1'b1);
        exp_t e;
        exp_t g;
        bus.out_req = req;
        bus.hold    = h;
        bus.err_clr = ec;
        clr         = c;
        model(req, h, ec, c);
        e = '{name, m_sel, m_valid, m_conf, m_cstk, m_istk, m_cnt};
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue: observed empty expected entry", name);
        end else begin
            g = q.pop_front();
            if (do_check) begin
                check({g.name, ".sel"},   32'(bus.bus_sel),         32'(g.sel));
                check({g.name, ".valid"}, 32'(bus.sel_valid),       32'(g.valid));
                check({g.name, ".conf"},  32'(bus.conflict),        32'(g.conf));
                check({g.name, ".cstk"},  32'(bus.conflict_sticky), 32'(g.cstk));
                check({g.name, ".istk"},  32'(bus.illegal_sticky),  32'(g.istk));
                check({g.name, ".cnt"},   32'(bus.conflict_cnt),    32'(g.cnt));
            end
        end
    endtask

    initial begin
        bus.out_req = '0;
        bus.hold    = 1'b0;
        bus.err_clr = 1'b0;
        clr         = 1'b1;

        // Reset with every request bit set
        step("rst0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        step("rst1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

        // Single grants, then idle
        step("r0",    32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step("pc",    32'h0010_0000, 1'b0, 1'b0, 1'b0);
        step("csx",   32'h0080_0000, 1'b0, 1'b0, 1'b0);
        step("idle",  32'h0000_0000, 1'b0, 1'b0, 1'b0);
        step("r15",   32'h0000_8000, 1'b0, 1'b0, 1'b0);

        // Priority under conflict, one-cycle pulse
        step("prio",  32'h0030_0002, 1'b0, 1'b0, 1'b0);
        step("pdrop", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // Saturation of the conflict counter
        for (int i = 0; i < 300; i++)
            step("sat", 32'h0030_0002, 1'b0, 1'b0, 1'b0, (i < 3 || i >= 250));

        // err_clr with no new event
        step("eclr",  32'h0000_0000, 1'b0, 1'b1, 1'b0);

        // Reserved-only, then reserved plus legal
        step("rsv",   32'h8000_0000, 1'b0, 1'b0, 1'b0);
        step("rsvl",  32'h8000_0010, 1'b0, 1'b0, 1'b0);
        step("eclr2", 32'h0000_0000, 1'b0, 1'b1, 1'b0);

        // Hold freezes the grant while error logic keeps counting
        step("r5",    32'h0000_0020, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("hold",  32'h0000_0600, 1'b1, 1'b0, 1'b0);
        step("hidle", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        step("ecev",  32'h0000_0600, 1'b0, 1'b1, 1'b0);

        // Mid-operation reset discards the grant
        step("mdr",   32'h0020_0000, 1'b0, 1'b0, 1'b0);
        step("mclr",  32'h0020_0000, 1'b0, 1'b0, 1'b1);
        step("mrel",  32'h0020_0000, 1'b0, 1'b0, 1'b0);
        step("hiidx", 32'h00C0_0000, 1'b0, 1'b0, 1'b0);

        if (q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL queue_drain: observed %0d entries expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
